sr595_driver: RTL and testbench

Serial transmitter for a chain of 74x595-style shift/storage registers. It accepts a parallel word over a valid/ready handshake and shifts it out MSB-first on SER/SRCLK. It then pulses RCLK so the far-end register chain transfers the word to its outputs. It sits between system logic and any 74x595 chain modelled in the library, and is the driving end of that serial interface.

---
 rtl/sr595_driver.sv | 81 ++++++++
 tb/tb_sr595_driver.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sr595_driver.sv
// sr595_driver: serial transmitter for a 74x595 shift/storage register chain.
// Shifts a parallel word out MSB-first on SER/SRCLK, then pulses RCLK to latch it.
module sr595_driver #(
    parameter int WIDTH = 8,
    parameter int DIV = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DATA,
    input  logic             VALID,
    output logic             READY,
    output logic             SER,
    output logic             SRCLK,
    output logic             RCLK,
    output logic             DONE
);
    localparam int DW = $clog2(DIV + 1);
    localparam int BW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;
    state_t state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_nxt;
    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;
    logic div_end;
    assign sr_nxt = sr << 1;
    assign div_end = div_cnt == DW'(DIV - 1);
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            sr <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            READY <= 1'b1;
            SER <= 1'b0;
            SRCLK <= 1'b0;
            RCLK <= 1'b0;
            DONE <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: if (VALID) begin
                    sr <= DATA;
                    bit_cnt <= BW'(WIDTH);
                    div_cnt <= '0;
                    SER <= DATA[WIDTH-1];
                    READY <= 1'b0;
                    state <= SHIFT_LO;
                end
                SHIFT_LO: if (div_end) begin
                    div_cnt <= '0;
                    SRCLK <= 1'b1;
                    state <= SHIFT_HI;
                end else div_cnt <= div_cnt + DW'(1);
                SHIFT_HI: if (div_end) begin
                    div_cnt <= '0;
                    bit_cnt <= bit_cnt - BW'(1);
                    SRCLK <= 1'b0;
                    // SER only moves on the SRCLK falling edge, giving DIV cycles of hold
                    if (bit_cnt != BW'(1)) begin
                        sr <= sr_nxt;
                        SER <= sr_nxt[WIDTH-1];
                        state <= SHIFT_LO;
                    end else begin
                        SER <= 1'b0;
                        RCLK <= 1'b1;
                        state <= LATCH;
                    end
                end else div_cnt <= div_cnt + DW'(1);
                LATCH: if (div_end) begin
                    div_cnt <= '0;
                    RCLK <= 1'b0;
                    READY <= 1'b1;
                    DONE <= 1'b1;
                    state <= IDLE;
                end else div_cnt <= div_cnt + DW'(1);
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sr595_driver.sv
// tb_sr595_driver: drives two sr595_driver instances (8/2 and 16/1) into
// behavioural 74x595 chain models and checks delivered words and frame timing.
module tb_sr595_driver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] da = '0;
    logic [15:0] db = '0;
    logic va = 1'b0, vb = 1'b0;
    logic ready_a, ser_a, srclk_a, rclk_a, done_a;
    logic ready_b, ser_b, srclk_b, rclk_b, done_b;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    sr595_driver #(.WIDTH(8), .DIV(2)) dut_a (
        .CLK(clk), .RST(rst), .DATA(da), .VALID(va), .READY(ready_a),
        .SER(ser_a), .SRCLK(srclk_a), .RCLK(rclk_a), .DONE(done_a)
    );
    sr595_driver #(.WIDTH(16), .DIV(1)) dut_b (
        .CLK(clk), .RST(rst), .DATA(db), .VALID(vb), .READY(ready_b),
        .SER(ser_b), .SRCLK(srclk_b), .RCLK(rclk_b), .DONE(done_b)
    );

    // far-end 74x595 chains: shift on SRCLK rise, transfer on RCLK rise, no reset
    logic [7:0] chain_a, store_a;
    logic [15:0] chain_b, store_b;
    int sr_cnt_a = 0, rc_cnt_a = 0, sr_cnt_b = 0, rc_cnt_b = 0;
    time last_a = 0, gap_a = 0, last_b = 0, gap_b = 0;
    always @(posedge srclk_a) begin
        chain_a <= {chain_a[6:0], ser_a};
        sr_cnt_a <= sr_cnt_a + 1;
        gap_a <= $time - last_a;
        last_a <= $time;
    end
    always @(posedge rclk_a) begin
        store_a <= chain_a;
        rc_cnt_a <= rc_cnt_a + 1;
    end
    always @(posedge srclk_b) begin
        chain_b <= {chain_b[14:0], ser_b};
        sr_cnt_b <= sr_cnt_b + 1;
        gap_b <= $time - last_b;
        last_b <= $time;
    end
    always @(posedge rclk_b) begin
        store_b <= chain_b;
        rc_cnt_b <= rc_cnt_b + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one complete frame; expected busy time is 2*DIV*WIDTH + DIV cycles
    task automatic frame(input bit sel, input logic [15:0] d, input string tag);
        int s0, r0, busy, n;
        logic [15:0] exp_word;
        exp_word = sel ? d : {8'h00, d[7:0]};
        s0 = sel ? sr_cnt_b : sr_cnt_a;
        r0 = sel ? rc_cnt_b : rc_cnt_a;
        n = 0;
        while (!(sel ? ready_b : ready_a) && n < 200) begin tick(); n++; end
        if (sel) begin db = d; vb = 1'b1; end else begin da = d[7:0]; va = 1'b1; end
        tick();
        vb = 1'b0;
        va = 1'b0;
        busy = 0;
        n = 0;
        while (!(sel ? done_b : done_a) && n < 200) begin
            if (!(sel ? ready_b : ready_a)) busy++;
            tick();
            n++;
        end
        chk({tag, " done"}, 32'(sel ? done_b : done_a), 1);
        chk({tag, " busy"}, busy, sel ? 33 : 34);
        chk({tag, " word"}, sel ? 32'(store_b) : 32'(store_a), 32'(exp_word));
        chk({tag, " srclk rises"}, (sel ? sr_cnt_b : sr_cnt_a) - s0, sel ? 16 : 8);
        chk({tag, " rclk rises"}, (sel ? rc_cnt_b : rc_cnt_a) - r0, 1);
        chk({tag, " srclk period"}, 32'(sel ? gap_b : gap_a), sel ? 20 : 40);
        tick();
        chk({tag, " done width"}, 32'(sel ? done_b : done_a), 0);
    endtask

    initial begin
        int n, s0, r0, dones;
        // reset with a valid word pending: nothing may be accepted
        va = 1'b1;
        da = 8'hFF;
        vb = 1'b1;
        db = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("reset outs a", {ser_a, srclk_a, rclk_a, done_a, ready_a}, 5'b00001);
            chk("reset outs b", {ser_b, srclk_b, rclk_b, done_b, ready_b}, 5'b00001);
        end
        chk("reset no shift", sr_cnt_a + sr_cnt_b, 0);
        va = 1'b0;
        vb = 1'b0;
        rst = 1'b0;
        tick();
        chk("idle after reset", {srclk_a, rclk_a, ready_a}, 3'b001);

        frame(1'b0, 16'h00A5, "single a5");

        // back-to-back: VALID held, second word presented on the DONE cycle
        da = 8'h0F;
        va = 1'b1;
        tick();
        n = 0;
        while (!done_a && n < 200) begin tick(); n++; end
        chk("b2b first done", 32'(done_a), 1);
        chk("b2b first word", 32'(store_a), 32'h0F);
        da = 8'hF0;
        tick();
        va = 1'b0;
        chk("b2b no gap", 32'(ready_a), 0);
        n = 0;
        while (!done_a && n < 200) begin tick(); n++; end
        chk("b2b second done", 32'(done_a), 1);
        chk("b2b second word", 32'(store_a), 32'hF0);
        tick();

        // busy ignore: VALID and changing DATA while a frame is in flight
        s0 = sr_cnt_a;
        da = 8'h3C;
        va = 1'b1;
        tick();
        dones = 0;
        n = 0;
        while (n < 60) begin
            da = 8'($urandom);
            if (done_a) begin dones++; va = 1'b0; end
            tick();
            n++;
        end
        va = 1'b0;
        chk("ignore word", 32'(store_a), 32'h3C);
        chk("ignore dones", dones, 1);
        chk("ignore srclk rises", sr_cnt_a - s0, 8);

        // reset after the 3rd SRCLK rise of 0x96
        s0 = sr_cnt_a;
        r0 = rc_cnt_a;
        da = 8'h96;
        va = 1'b1;
        tick();
        va = 1'b0;
        n = 0;
        while (sr_cnt_a - s0 < 3 && n < 100) begin tick(); n++; end
        chk("midreset reached", sr_cnt_a - s0, 3);
        #2 rst = 1'b1;
        #1 chk("midreset outs", {ser_a, srclk_a, rclk_a, done_a, ready_a}, 5'b00001);
        tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("midreset no rclk", rc_cnt_a - r0, 0);
        chk("midreset store kept", 32'(store_a), 32'h3C);
        frame(1'b0, 16'h005A, "after reset 5a");

        frame(1'b1, 16'hBEEF, "corner beef");

        for (int i = 0; i < 6; i++) begin
            frame(1'b0, 16'($urandom), "rand a");
            repeat ($urandom_range(0, 3)) tick();
        end
        for (int i = 0; i < 4; i++) begin
            frame(1'b1, 16'($urandom), "rand b");
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
